// File: rtl/uart_pkg.sv
// Shared definitions for the word UART link: transmitter state encoding and
// helpers that turn link parameters into bit timing and counter widths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Clock cycles per serial bit (integer division, truncating).
  function automatic int clks_per_bit(input int clq_freq, input int baud_rate);
    return clq_freq / baud_rate;
  endfunction

  // Number of serial frames needed to carry one word.
  function automatic int word_parts(input int word_size, input int word_part);
    return word_size / word_part;
  endfunction

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/baud_counter.sv
// Free-running bit-period counter. Counts 0..CLKS_PER_BIT-1 and flags the
// terminal count; clear holds it at zero so a new bit period starts cleanly.
module baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_reg;

  // Count cycles within a bit, wrapping on terminal count.
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      count_reg <= '0;
    end else if (tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tick = (count_reg == LAST);

endmodule

// File: rtl/uart_word_tx.sv
// Word-level UART transmitter. Accepts one word per valid/ready handshake and
// sends it as WORD_SIZE/WORD_PART back-to-back 8N1-style frames, least
// significant part first and each part LSB first.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int WORD_PART = 8,
  parameter int CLQ_FREQ  = 200_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 w_valid,
  output logic                 ready,
  output logic                 sig_out,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLQ_FREQ, BAUD_RATE);
  localparam int PARTS        = word_parts(WORD_SIZE, WORD_PART);
  localparam int BIT_W        = cnt_width(WORD_PART);
  localparam int PART_W       = cnt_width(PARTS);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_PART - 1);
  localparam logic [PART_W-1:0] LAST_PART = PART_W'(PARTS - 1);

  // Reject parameter sets that cannot be framed correctly.
  generate
    if ((WORD_SIZE % WORD_PART) != 0) begin : g_bad_split
      $error("uart_word_tx: WORD_SIZE must be a multiple of WORD_PART");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_word_tx: CLQ_FREQ/BAUD_RATE must be at least 2");
    end
  endgenerate

  tx_state_t             state_reg, state_next;
  logic [WORD_SIZE-1:0]  shift_reg, shift_next;
  logic [BIT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [PART_W-1:0]     part_cnt_reg, part_cnt_next;
  logic                  sig_reg, sig_next;
  logic                  tick;
  logic                  clear;

  // Bit timing restarts from zero on the accept edge because the counter is
  // held clear for the whole time the transmitter sits idle.
  assign clear = (state_reg == IDLE);

  baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .tick (tick)
  );

  // State and datapath registers; the line itself is registered so it never
  // glitches and has no path from the inputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      part_cnt_reg <= '0;
      sig_reg      <= 1'b1;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      part_cnt_reg <= part_cnt_next;
      sig_reg      <= sig_next;
    end
  end

  // Next-state logic. The whole word shifts right one bit per data bit, so
  // after one part the next part's LSB is already sitting in bit 0.
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    part_cnt_next = part_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (w_valid) begin
          shift_next    = data_in;
          bit_cnt_next  = '0;
          part_cnt_next = '0;
          state_next    = START;
        end
      end
      START: begin
        if (tick) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt_reg == LAST_BIT) begin
            bit_cnt_next = '0;
            state_next   = STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (part_cnt_reg != LAST_PART) begin
            part_cnt_next = part_cnt_reg + 1'b1;
            state_next    = START;
          end else begin
            part_cnt_next = '0;
            state_next    = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic: line level for the upcoming state, plus handshake flags.
  always_comb begin
    sig_next = 1'b1;
    case (state_next)
      START:   sig_next = 1'b0;
      DATA:    sig_next = shift_next[0];
      default: sig_next = 1'b1;
    endcase
    ready = (state_reg == IDLE);
    busy  = (state_reg != IDLE);
  end

  assign sig_out = sig_reg;

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: directed stimulus pushes sent words
// into a scoreboard queue; a mid-bit sampling receiver model pops and checks.
module tb_uart_word_tx;

  localparam int CPB   = 10;
  localparam int FRAME = 10 * CPB;
  localparam int WORDT = 4 * FRAME;

  logic        clock;
  logic        reset;
  logic [31:0] data_in;
  logic        w_valid;
  logic        ready;
  logic        sig_out;
  logic        busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb_q[$];
  int          mon_part = 0;
  logic [31:0] mon_acc;

  uart_word_tx #(
    .WORD_SIZE(32),
    .WORD_PART(8),
    .CLQ_FREQ (1_000_000),
    .BAUD_RATE(100_000)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .data_in(data_in),
    .w_valid(w_valid),
    .ready  (ready),
    .sig_out(sig_out),
    .busy   (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected line level k cycles after the accept edge of word w.
  function automatic logic exp_bit(input logic [31:0] w, input int k);
    int part;
    int pos;
    logic [7:0] b;
    part = k / FRAME;
    pos  = (k % FRAME) / CPB;
    b    = w[part*8 +: 8];
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clock);
    while (ready !== 1'b1 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (ready !== 1'b1) check("ready_timeout", {31'd0, ready}, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clock);
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (busy !== 1'b0) check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Hand one word over; returns just after the accept edge.
  task automatic issue(input logic [31:0] w);
    wait_ready();
    data_in = w;
    w_valid = 1'b1;
    sb_q.push_back(w);
    $display("[TB] send word 0x%08h", w);
    @(posedge clock);
    #1;
    w_valid = 1'b0;
  endtask

  // Receiver model: waits n cycles, flags any reset seen meanwhile.
  task automatic mon_wait(input int n, output bit ab);
    ab = 1'b0;
    repeat (n) begin
      @(negedge clock);
      if (!reset) ab = 1'b1;
    end
  endtask

  // Monitor: decode frames at mid-bit, assemble words, compare against queue.
  initial begin : p_monitor
    logic       prev;
    logic [7:0] rx_byte;
    bit         ab;
    logic [31:0] exp_w;
    prev = 1'b1;
    rx_byte = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        mon_part = 0;
        prev = 1'b1;
      end else if (prev === 1'b1 && sig_out === 1'b0) begin
        mon_wait(CPB / 2, ab);
        if (!ab) check("rx_start_bit", {31'd0, sig_out}, 32'd0);
        for (int b = 0; b < 8; b++) begin
          if (!ab) begin
            mon_wait(CPB, ab);
            rx_byte[b] = sig_out;
          end
        end
        if (!ab) mon_wait(CPB, ab);
        if (ab) begin
          mon_part = 0;
          prev = 1'b1;
        end else begin
          check("rx_stop_bit", {31'd0, sig_out}, 32'd1);
          mon_acc[mon_part*8 +: 8] = rx_byte;
          mon_part++;
          if (mon_part == 4) begin
            mon_part = 0;
            $display("[TB] recv word 0x%08h", mon_acc);
            if (sb_q.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL rx_unexpected: got 0x%08h expected no word", mon_acc);
            end else begin
              exp_w = sb_q.pop_front();
              check("rx_word", mon_acc, exp_w);
            end
          end
          prev = sig_out;
        end
      end else begin
        prev = sig_out;
      end
    end
  end

  initial begin : p_watchdog
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : p_stim
    int   err;
    int   busy_err;
    logic [31:0] w;
    reset   = 1'b0;
    w_valid = 1'b1;
    data_in = 32'hCAFEF00D;

    // 1: reset held with w_valid high
    repeat (3) begin
      @(negedge clock);
      check("t1_sig_out", {31'd0, sig_out}, 32'd1);
      check("t1_ready", {31'd0, ready}, 32'd1);
      check("t1_busy", {31'd0, busy}, 32'd0);
    end
    w_valid = 1'b0;
    reset   = 1'b1;
    repeat (3) @(negedge clock);
    check("t1_no_frame", {31'd0, sig_out}, 32'd1);
    $display("[TB] reset test done");

    // 2: single word, cycle-exact line and busy
    issue(32'hA5C30F81);
    err = 0;
    busy_err = 0;
    for (int k = 0; k < WORDT; k++) begin
      @(negedge clock);
      if (sig_out !== exp_bit(32'hA5C30F81, k)) err++;
      if (busy !== 1'b1) busy_err++;
    end
    check("t2_line_errors", err, 0);
    check("t2_busy_errors", busy_err, 0);
    @(negedge clock);
    check("t2_busy_done", {31'd0, busy}, 32'd0);
    check("t2_ready_done", {31'd0, ready}, 32'd1);
    check("t2_idle_line", {31'd0, sig_out}, 32'd1);

    // 3: back-to-back words with w_valid held
    wait_ready();
    data_in = 32'h00000000;
    w_valid = 1'b1;
    sb_q.push_back(32'h00000000);
    $display("[TB] send word 0x00000000");
    @(posedge clock);
    #1;
    data_in = 32'hFFFFFFFF;
    sb_q.push_back(32'hFFFFFFFF);
    $display("[TB] send word 0xffffffff");
    err = 0;
    for (int k = 0; k <= 2 * WORDT + 1; k++) begin
      @(negedge clock);
      if (k < WORDT) begin
        if (sig_out !== exp_bit(32'h00000000, k)) err++;
      end else if (k == WORDT) begin
        if (sig_out !== 1'b1) err++;
        check("t3_gap_ready", {31'd0, ready}, 32'd1);
        check("t3_gap_busy", {31'd0, busy}, 32'd0);
      end else if (k <= 2 * WORDT) begin
        if (k == WORDT + 1) begin
          check("t3_second_accept", {31'd0, busy}, 32'd1);
          w_valid = 1'b0;
        end
        if (sig_out !== exp_bit(32'hFFFFFFFF, k - WORDT - 1)) err++;
      end else begin
        check("t3_final_busy", {31'd0, busy}, 32'd0);
      end
    end
    check("t3_line_errors", err, 0);

    // 4: w_valid pulse while busy is ignored
    issue(32'hDEADBEEF);
    repeat (50) @(negedge clock);
    check("t4_ready_before", {31'd0, ready}, 32'd0);
    data_in = 32'h12345678;
    w_valid = 1'b1;
    @(negedge clock);
    check("t4_ready_during", {31'd0, ready}, 32'd0);
    w_valid = 1'b0;
    data_in = 32'h0;
    wait_idle();
    repeat (5) @(negedge clock);
    check("t4_queue_empty", sb_q.size(), 0);
    check("t4_stays_idle", {31'd0, busy}, 32'd0);

    // 5: reset during data bit 3 of part 2
    w = 32'hDE00ABCD;
    issue(w);
    for (int k = 0; k <= 2 * FRAME + CPB + 3 * CPB + 4; k++) begin
      @(negedge clock);
    end
    check("t5_bit_before_reset", {31'd0, sig_out}, {31'd0, exp_bit(w, 2 * FRAME + CPB + 3 * CPB + 4)});
    reset = 1'b0;
    @(negedge clock);
    check("t5_reset_sig_out", {31'd0, sig_out}, 32'd1);
    check("t5_reset_ready", {31'd0, ready}, 32'd1);
    check("t5_reset_busy", {31'd0, busy}, 32'd0);
    sb_q.delete();
    @(negedge clock);
    reset = 1'b1;
    issue(32'h00000055);
    wait_idle();
    repeat (5) @(negedge clock);
    check("t5_queue_empty", sb_q.size(), 0);

    // 6: random words through the receiver model
    for (int i = 0; i < 100; i++) begin
      issue($urandom);
    end
    wait_idle();
    repeat (20) @(negedge clock);
    check("t6_queue_empty", sb_q.size(), 0);
    check("t6_rx_aligned", mon_part, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
